uart_cmd_bridge: RTL

Byte-level command processor sitting directly downstream of the UART/FIFO block. It pops received bytes, parses fixed 5-byte command frames, performs single register reads or writes on a simple register bus, and pushes a 4-byte response frame back into the UART transmit FIFO. It lets a host PC access on-chip control/status registers over the serial link.

---
 rtl/uart_cmd_bridge_if.sv | 31 +++
 rtl/uart_cmd_bridge.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_bridge_if.sv
// uart_cmd_bridge_if
//   Groups the byte FIFO handshakes and the register bus of the UART
//   command bridge.
//   RX FIFO side : r_data, rx_empty (to bridge), rd_uart (from bridge)
//   TX FIFO side : w_data, wr_uart (from bridge), tx_full (to bridge)
//   Register bus : reg_addr, reg_wdata, reg_we, reg_re (from bridge),
//                  reg_rdata (to bridge, valid the cycle after reg_re)
//   master = the bridge, slave = the FIFO/register environment.
interface uart_cmd_bridge_if;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       tx_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (
    input  r_data, rx_empty, tx_full, reg_rdata,
    output rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    output r_data, rx_empty, tx_full, reg_rdata,
    input  rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge
//   Pops bytes from the UART RX FIFO, parses 5-byte command frames
//   (SYNC, CMD, ADDR, DATA, CHK with CHK = CMD^ADDR^DATA), performs one
//   register write (CMD 01) or read (CMD 02), and pushes a 4-byte response
//   (RESP, STATUS, RDATA, STATUS^RDATA) into the TX FIFO.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : uart_cmd_bridge_if.master (RX/TX FIFO handshakes, reg bus)
//     busy     : high whenever the parser is not hunting for SYNC
//     err_cnt  : saturating count of rejected or timed-out frames
module uart_cmd_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  RESP_BYTE      = 8'h5A
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_bridge_if.master  bus,
  output logic               busy,
  output logic [7:0]         err_cnt
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] ST_OK   = 8'h00;
  localparam logic [7:0] ST_CHK  = 8'h01;
  localparam logic [7:0] ST_CMD  = 8'h02;

  typedef enum logic [2:0] {
    HUNT, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_WAIT, SEND
  } state_t;

  state_t state, state_n;

  logic [TMO_W-1:0] tmo_cnt;
  logic [1:0]       idx;
  logic [7:0]       addr_hold, wdata_hold;
  logic [7:0]       cmd_q, addr_q, data_q, chk_q;
  logic [7:0]       status_q, rdata_q;
  logic [7:0]       status_c;
  logic             err_inc;
  logic             in_get;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Checksum is judged before the command code.
  function automatic logic [7:0] frame_status(input logic [7:0] c, input logic [7:0] a,
                                              input logic [7:0] d, input logic [7:0] k);
    if ((c ^ a ^ d) != k)              return ST_CHK;
    else if (c != CMD_WR && c != CMD_RD) return ST_CMD;
    else                               return ST_OK;
  endfunction

  function automatic logic [7:0] resp_byte(input logic [1:0] i, input logic [7:0] st,
                                           input logic [7:0] rd);
    case (i)
      2'd0:    return RESP_BYTE;
      2'd1:    return st;
      2'd2:    return rd;
      default: return st ^ rd;
    endcase
  endfunction

  assign status_c = frame_status(cmd_q, addr_q, data_q, chk_q);
  assign in_get   = (state == GET_CMD) || (state == GET_ADDR) ||
                    (state == GET_DATA) || (state == GET_CHK);
  assign busy     = (state != HUNT);

  always_comb begin
    state_n       = state;
    bus.rd_uart   = 1'b0;
    bus.wr_uart   = 1'b0;
    bus.w_data    = 8'h00;
    bus.reg_we    = 1'b0;
    bus.reg_re    = 1'b0;
    bus.reg_addr  = addr_hold;
    bus.reg_wdata = wdata_hold;
    err_inc       = 1'b0;
    case (state)
      HUNT: begin
        if (!bus.rx_empty) begin
          bus.rd_uart = 1'b1;
          if (bus.r_data == SYNC_BYTE) state_n = GET_CMD;
        end
      end
      GET_CMD, GET_ADDR, GET_DATA, GET_CHK: begin
        if (!bus.rx_empty) begin
          bus.rd_uart = 1'b1;
          case (state)
            GET_CMD:  state_n = GET_ADDR;
            GET_ADDR: state_n = GET_DATA;
            GET_DATA: state_n = GET_CHK;
            default:  state_n = EXEC;
          endcase
        end else if (tmo_cnt == TMO_LAST) begin
          // Inter-byte gap expired: drop the frame without a response.
          state_n = HUNT;
          err_inc = 1'b1;
        end
      end
      EXEC: begin
        if (status_c != ST_OK) begin
          err_inc = 1'b1;
          state_n = SEND;
        end else if (cmd_q == CMD_WR) begin
          bus.reg_we    = 1'b1;
          bus.reg_addr  = addr_q;
          bus.reg_wdata = data_q;
          state_n       = SEND;
        end else begin
          bus.reg_re   = 1'b1;
          bus.reg_addr = addr_q;
          state_n      = RD_WAIT;
        end
      end
      RD_WAIT: state_n = SEND;
      SEND: begin
        if (!bus.tx_full) begin
          bus.wr_uart = 1'b1;
          bus.w_data  = resp_byte(idx, status_q, rdata_q);
          if (idx == 2'd3) state_n = HUNT;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // Control state: FSM, inter-byte timer, response index, error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      tmo_cnt    <= '0;
      idx        <= 2'd0;
      err_cnt    <= 8'h00;
      addr_hold  <= 8'h00;
      wdata_hold <= 8'h00;
    end else begin
      state <= state_n;
      if (err_inc) err_cnt <= sat_inc(err_cnt);
      if (!in_get || bus.rd_uart) tmo_cnt <= '0;
      else                        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (state != SEND)    idx <= 2'd0;
      else if (bus.wr_uart) idx <= idx + 2'd1;
      if (bus.reg_we || bus.reg_re) addr_hold  <= addr_q;
      if (bus.reg_we)               wdata_hold <= data_q;
    end
  end

  // Frame fields and response payload.
  always_ff @(posedge clk) begin
    if (bus.rd_uart) begin
      case (state)
        GET_CMD:  cmd_q  <= bus.r_data;
        GET_ADDR: addr_q <= bus.r_data;
        GET_DATA: data_q <= bus.r_data;
        GET_CHK:  chk_q  <= bus.r_data;
        default:  ;
      endcase
    end
    if (state == EXEC) begin
      status_q <= status_c;
      rdata_q  <= (status_c == ST_OK && cmd_q == CMD_WR) ? data_q : 8'h00;
    end else if (state == RD_WAIT) begin
      rdata_q <= bus.reg_rdata;
    end
  end

endmodule
